dac_axis_sample_unpacker: RTL and testbench

DAC_AXIS_SAMPLE_UNPACKER -- requirements
Module: dac_axis_sample_unpacker

---
 rtl/dac_axis_sample_unpacker.sv | 232 +++++++++++++++++++++++
 tb/tb_dac_axis_sample_unpacker.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_axis_sample_unpacker.sv
// AXI-stream to DAC sample unpacker: buffers 64-bit words holding two IQ samples
// and plays them out one sample per clock under an enable-driven FSM.
module dac_axis_sample_unpacker #(
    parameter int FIFO_DEPTH  = 16,
    parameter int PRIME_LEVEL = 2
) (
    input  logic                          clk_245_76MHz,
    input  logic                          cpu_reset,
    input  logic [63:0]                   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic [7:0]                    s_axis_tkeep,
    input  logic                          dac_enable,
    input  logic                          fifo_flush,
    output logic [15:0]                   dac_data_i,
    output logic [15:0]                   dac_data_q,
    output logic                          dac_data_valid,
    output logic                          frame_done,
    output logic                          underrun,
    output logic [15:0]                   underrun_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_STOP
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [63:0]    r_mem_data  [FIFO_DEPTH];
    logic           r_mem_last  [FIFO_DEPTH];
    logic           r_mem_keep4 [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [LW-1:0]  r_level;
    logic [LW-1:0]  r_last_cnt;
    logic           r_rdy_en;
    logic           r_en_r;
    logic           r_en_rr;
    logic           r_half;

    logic [15:0]    r_dac_i;
    logic [15:0]    r_dac_q;
    logic           r_valid;
    logic           r_frame_done;
    logic           r_underrun;
    logic [15:0]    r_ucount;

    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_emit;
    logic           w_frame_end;
    logic           w_under;
    logic           w_half_nxt;
    logic [31:0]    w_sample;
    logic [63:0]    w_head_data;
    logic           w_head_last;
    logic           w_head_keep4;
    logic           w_last_inc;
    logic           w_last_dec;
    logic           w_unused_keep;

    assign w_unused_keep = ^{s_axis_tkeep[7:5], s_axis_tkeep[3:0]};

    assign w_full        = (r_level == LW'(FIFO_DEPTH));
    assign w_empty       = (r_level == '0);
    assign s_axis_tready = r_rdy_en && !w_full;
    assign w_push        = s_axis_tvalid && s_axis_tready && !fifo_flush;

    assign w_head_data   = r_mem_data[r_rd_ptr];
    assign w_head_last   = r_mem_last[r_rd_ptr];
    assign w_head_keep4  = r_mem_keep4[r_rd_ptr];

    assign w_last_inc    = w_push && s_axis_tlast;
    assign w_last_dec    = w_pop && w_head_last;

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_pop       = 1'b0;
        w_frame_end = 1'b0;
        w_under     = 1'b0;
        w_half_nxt  = r_half;
        w_sample    = r_half ? w_head_data[63:32] : w_head_data[31:0];

        case (r_state)
            ST_IDLE: begin
                if (r_en_rr)
                    w_state_nxt = ST_PRIME;
            end
            ST_PRIME: begin
                if (!r_en_rr)
                    w_state_nxt = ST_IDLE;
                else if (r_level >= LW'(PRIME_LEVEL) || r_last_cnt != '0)
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!r_en_rr) begin
                    w_state_nxt = ST_STOP;
                end else if (w_empty) begin
                    w_under = 1'b1;
                end else begin
                    w_emit = 1'b1;
                    if (r_half || !w_head_keep4) begin
                        w_pop       = 1'b1;
                        w_half_nxt  = 1'b0;
                        w_frame_end = w_head_last;
                    end else begin
                        w_half_nxt  = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                w_state_nxt = ST_IDLE;
                if (r_half && !w_empty) begin
                    w_emit      = 1'b1;
                    w_pop       = 1'b1;
                    w_half_nxt  = 1'b0;
                    w_frame_end = w_head_last;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Flush drops the partially played word and never lets playback (re)start this cycle.
        if (fifo_flush) begin
            w_emit      = 1'b0;
            w_pop       = 1'b0;
            w_under     = 1'b0;
            w_frame_end = 1'b0;
            w_half_nxt  = 1'b0;
            if (r_state == ST_RUN)
                w_state_nxt = ST_PRIME;
            else if (r_state == ST_STOP)
                w_state_nxt = ST_IDLE;
            else if (w_state_nxt == ST_RUN)
                w_state_nxt = ST_PRIME;
        end
    end

    always_ff @(posedge clk_245_76MHz) begin
        if (w_push && !cpu_reset) begin
            r_mem_data[r_wr_ptr]  <= s_axis_tdata;
            r_mem_last[r_wr_ptr]  <= s_axis_tlast;
            r_mem_keep4[r_wr_ptr] <= s_axis_tkeep[4];
        end
    end

    always_ff @(posedge clk_245_76MHz) begin
        if (cpu_reset) begin
            r_state  <= ST_IDLE;
            r_rdy_en <= 1'b0;
            r_en_r   <= 1'b0;
            r_en_rr  <= 1'b0;
            r_half   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rdy_en <= 1'b1;
            r_en_r   <= dac_enable;
            r_en_rr  <= r_en_r;
            r_half   <= w_half_nxt;
        end
    end

    always_ff @(posedge clk_245_76MHz) begin
        if (cpu_reset || fifo_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_last_cnt <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            case ({w_last_inc, w_last_dec})
                2'b10:   r_last_cnt <= r_last_cnt + LW'(1);
                2'b01:   r_last_cnt <= r_last_cnt - LW'(1);
                default: r_last_cnt <= r_last_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_245_76MHz) begin
        if (cpu_reset) begin
            r_dac_i      <= '0;
            r_dac_q      <= '0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_dac_i      <= w_emit ? w_sample[31:16] : '0;
            r_dac_q      <= w_emit ? w_sample[15:0]  : '0;
            r_valid      <= w_emit;
            r_frame_done <= w_emit && w_frame_end;
        end
    end

    always_ff @(posedge clk_245_76MHz) begin
        if (cpu_reset || fifo_flush) begin
            r_underrun <= 1'b0;
            r_ucount   <= '0;
        end else if (w_under) begin
            r_underrun <= 1'b1;
            if (r_ucount != 16'hFFFF)
                r_ucount <= r_ucount + 16'd1;
        end
    end

    assign dac_data_i     = r_dac_i;
    assign dac_data_q     = r_dac_q;
    assign dac_data_valid = r_valid;
    assign frame_done     = r_frame_done;
    assign underrun       = r_underrun;
    assign underrun_count = r_ucount;
    assign fifo_level     = r_level;

endmodule

// File: tb/tb_dac_axis_sample_unpacker.sv
// Self-checking bench for dac_axis_sample_unpacker: table-driven frames plus
// hand-written sequences, with a scoreboard of expected output samples.
module tb_dac_axis_sample_unpacker;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          cpu_reset;
    logic [63:0]   s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [7:0]    s_axis_tkeep;
    logic          dac_enable;
    logic          fifo_flush;
    logic [15:0]   dac_data_i;
    logic [15:0]   dac_data_q;
    logic          dac_data_valid;
    logic          frame_done;
    logic          underrun;
    logic [15:0]   underrun_count;
    logic [LW-1:0] fifo_level;

    always #2 clk = ~clk;

    dac_axis_sample_unpacker #(
        .FIFO_DEPTH  (DEPTH),
        .PRIME_LEVEL (2)
    ) dut (
        .clk_245_76MHz  (clk),
        .cpu_reset      (cpu_reset),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tkeep   (s_axis_tkeep),
        .dac_enable     (dac_enable),
        .fifo_flush     (fifo_flush),
        .dac_data_i     (dac_data_i),
        .dac_data_q     (dac_data_q),
        .dac_data_valid (dac_data_valid),
        .frame_done     (frame_done),
        .underrun       (underrun),
        .underrun_count (underrun_count),
        .fifo_level     (fifo_level)
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [7:0]  keep;
        int unsigned n;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    typedef struct {
        logic [31:0] iq;
        logic        fd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_on = 1'b0;
    bit   contig_on = 1'b0;
    bit   seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input logic l, input logic [7:0] k, input bit add_exp);
        int unsigned guard = 0;
        @(negedge clk);
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tkeep  = k;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            check("push_ready_timeout", 64'(s_axis_tready), 64'd1);
            s_axis_tvalid = 1'b0;
        end else begin
            @(posedge clk);
            #1 s_axis_tvalid = 1'b0;
            if (add_exp) begin
                sb.push_back('{d[31:0], l && !k[4]});
                if (k[4])
                    sb.push_back('{d[63:32], l});
            end
        end
    endtask

    task automatic wait_drain(input string name, input int unsigned budget);
        int unsigned c = 0;
        while (sb.size() != 0 && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        check({name, "_drained"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_valid(input string name, input int unsigned budget);
        int unsigned c = 0;
        while (!dac_data_valid && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        check({name, "_valid_seen"}, 64'(dac_data_valid), 64'd1);
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
        #1;
    endtask

    initial begin
        vec_t tv [4];
        logic [63:0] wc;
        int unsigned c;

        tv[0] = '{64'h1111_2222_3333_4444, 1'b0, 8'hFF, 2, 32'h3333_4444, 32'h1111_2222};
        tv[1] = '{64'h5555_6666_7777_8888, 1'b1, 8'hFF, 2, 32'h7777_8888, 32'h5555_6666};
        tv[2] = '{64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 8'hFF, 2, 32'hCCCC_DDDD, 32'hAAAA_BBBB};
        tv[3] = '{64'h0123_4567_89AB_CDEF, 1'b1, 8'h0F, 1, 32'h89AB_CDEF, 32'h0000_0000};

        cpu_reset     = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tkeep  = '0;
        dac_enable    = 1'b0;
        fifo_flush    = 1'b0;

        fork
            begin
                #1_000_000;
                $display("FAIL watchdog: simulation exceeded time limit");
                $fatal(1, "watchdog");
            end
            forever begin
                @(negedge clk);
                if (mon_on) begin
                    if (contig_on && seen && sb.size() != 0)
                        check("contiguous_valid", 64'(dac_data_valid), 64'd1);
                    if (dac_data_valid) begin
                        seen = 1'b1;
                        check("sample_expected", 64'(sb.size() != 0), 64'd1);
                        if (sb.size() != 0) begin
                            exp_t e;
                            e = sb.pop_front();
                            check("sample_iq", 64'({dac_data_i, dac_data_q}), 64'(e.iq));
                            check("sample_frame_done", 64'(frame_done), 64'(e.fd));
                        end
                    end else begin
                        check("idle_data", 64'({dac_data_i, dac_data_q}), 64'd0);
                        check("idle_frame_done", 64'(frame_done), 64'd0);
                    end
                end
            end
        join_none

        // Reset state
        tick(3);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_valid", 64'(dac_data_valid), 64'd0);
        check("rst_data", 64'({dac_data_i, dac_data_q}), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);
        check("rst_ucount", 64'(underrun_count), 64'd0);
        @(negedge clk);
        cpu_reset = 1'b0;
        #1;
        check("rel_tready_before_edge", 64'(s_axis_tready), 64'd0);
        tick(1);
        check("rel_tready_after_edge", 64'(s_axis_tready), 64'd1);
        mon_on = 1'b1;

        // Table-driven frames, played back-to-back
        for (int i = 0; i < 4; i++) begin
            push(tv[i].data, tv[i].last, tv[i].keep, 1'b0);
            sb.push_back('{tv[i].e0, tv[i].last && tv[i].n == 1});
            if (tv[i].n == 2)
                sb.push_back('{tv[i].e1, tv[i].last});
        end
        tick(1);
        check("table_level", 64'(fifo_level), 64'd4);
        seen = 1'b0;
        contig_on = 1'b1;
        dac_enable = 1'b1;
        wait_drain("table", 40);
        contig_on = 1'b0;
        dac_enable = 1'b0;
        tick(6);
        pulse_flush();
        check("flush1_level", 64'(fifo_level), 64'd0);
        check("flush1_underrun", 64'(underrun), 64'd0);
        check("flush1_ucount", 64'(underrun_count), 64'd0);

        // Single-sample tlast word, then underrun counting
        push(64'hDEAD_BEEF_CAFE_F00D, 1'b1, 8'h0F, 1'b1);
        dac_enable = 1'b1;
        wait_drain("keep0f", 20);
        check("keep0f_ucount_at_sample", 64'(underrun_count), 64'd0);
        tick(1);
        check("keep0f_underrun_set", 64'(underrun), 64'd1);
        check("keep0f_ucount_1", 64'(underrun_count), 64'd1);
        tick(5);
        check("keep0f_ucount_6", 64'(underrun_count), 64'd6);

        // Saturating underrun count, then flush with a colliding input word
        repeat (70000) @(posedge clk);
        tick(1);
        check("sat_ucount", 64'(underrun_count), 64'hFFFF);
        check("sat_underrun", 64'(underrun), 64'd1);
        @(negedge clk);
        fifo_flush    = 1'b1;
        s_axis_tdata  = 64'h9999_8888_7777_6666;
        s_axis_tkeep  = 8'hFF;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        fifo_flush    = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        check("flush2_ucount", 64'(underrun_count), 64'd0);
        check("flush2_underrun", 64'(underrun), 64'd0);
        check("flush2_level", 64'(fifo_level), 64'd0);
        tick(3);
        check("flush2_level_hold", 64'(fifo_level), 64'd0);
        check("flush2_no_underrun", 64'(underrun_count), 64'd0);
        dac_enable = 1'b0;
        tick(4);

        // Fill to full with playback disabled
        for (int i = 0; i < DEPTH; i++) begin
            wc = {16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h3000 + 16'(i), 16'h4000 + 16'(i)};
            push(wc, i == DEPTH - 1, 8'hFF, 1'b1);
        end
        tick(1);
        check("full_tready", 64'(s_axis_tready), 64'd0);
        check("full_level", 64'(fifo_level), 64'(DEPTH));
        dac_enable = 1'b1;
        wait_valid("full", 20);
        check("full_tready_at_s0", 64'(s_axis_tready), 64'd0);
        tick(1);
        check("full_tready_after_pop", 64'(s_axis_tready), 64'd1);
        check("full_level_after_pop", 64'(fifo_level), 64'(DEPTH - 1));
        wait_drain("full", 60);
        dac_enable = 1'b0;
        tick(6);

        // Enable dropped mid-stream: current word finishes, later word stays buffered
        push(64'hA1A1_A2A2_A3A3_A4A4, 1'b0, 8'hFF, 1'b1);
        push(64'hB1B1_B2B2_B3B3_B4B4, 1'b0, 8'hFF, 1'b1);
        wc = 64'hC1C1_C2C2_C3C3_C4C4;
        push(wc, 1'b1, 8'hFF, 1'b0);
        tick(1);
        dac_enable = 1'b1;
        wait_valid("stop", 20);
        dac_enable = 1'b0;
        tick(12);
        check("stop_sb_empty", 64'(sb.size()), 64'd0);
        check("stop_level", 64'(fifo_level), 64'd1);
        check("stop_valid_low", 64'(dac_data_valid), 64'd0);
        sb.push_back('{wc[31:0], 1'b0});
        sb.push_back('{wc[63:32], 1'b1});
        dac_enable = 1'b1;
        wait_drain("resume", 20);
        dac_enable = 1'b0;
        tick(6);

        // Reset asserted mid-frame
        push(64'hD1D1_D2D2_D3D3_D4D4, 1'b0, 8'hFF, 1'b1);
        push(64'hE1E1_E2E2_E3E3_E4E4, 1'b0, 8'hFF, 1'b1);
        push(64'hF1F1_F2F2_F3F3_F4F4, 1'b1, 8'hFF, 1'b1);
        dac_enable = 1'b1;
        c = 0;
        while (sb.size() > 4 && c < 20) begin
            @(negedge clk);
            #1;
            c++;
        end
        check("midrst_started", 64'(sb.size()), 64'd4);
        check("midrst_pre_ucount", 64'(underrun_count), 64'(underrun_count));
        cpu_reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_valid", 64'(dac_data_valid), 64'd0);
        check("midrst_data", 64'({dac_data_i, dac_data_q}), 64'd0);
        check("midrst_frame_done", 64'(frame_done), 64'd0);
        check("midrst_tready", 64'(s_axis_tready), 64'd0);
        check("midrst_level", 64'(fifo_level), 64'd0);
        check("midrst_underrun", 64'(underrun), 64'd0);
        check("midrst_ucount", 64'(underrun_count), 64'd0);
        sb.delete();
        dac_enable = 1'b0;
        tick(2);
        check("midrst_hold_tready", 64'(s_axis_tready), 64'd0);
        cpu_reset = 1'b0;
        tick(1);
        check("midrst_rel_tready", 64'(s_axis_tready), 64'd1);
        check("midrst_rel_valid", 64'(dac_data_valid), 64'd0);

        tick(3);
        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
